// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : Opcodes, FSM states and datapath-select encodings for the
//            multi-cycle controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  // Architectural opcodes (zero-extended when OPCODE_W is wider)
  localparam logic [4:0] c_op_r    = 5'b00000;
  localparam logic [4:0] c_op_j    = 5'b00001;
  localparam logic [4:0] c_op_jal  = 5'b00011;
  localparam logic [4:0] c_op_jr   = 5'b00100;
  localparam logic [4:0] c_op_addi = 5'b00101;
  localparam logic [4:0] c_op_sw   = 5'b00111;
  localparam logic [4:0] c_op_lw   = 5'b01000;
  localparam logic [4:0] c_op_setx = 5'b10101;
  localparam logic [4:0] c_op_bex  = 5'b10110;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] c_pc_sel_inc  = 2'd0;
  localparam logic [1:0] c_pc_sel_jump = 2'd1;
  localparam logic [1:0] c_pc_sel_rd   = 2'd2;

  localparam logic [1:0] c_rf_dst_rd   = 2'd0;
  localparam logic [1:0] c_rf_dst_r31  = 2'd1;
  localparam logic [1:0] c_rf_dst_r30  = 2'd2;

  localparam logic [1:0] c_wb_sel_alu  = 2'd0;
  localparam logic [1:0] c_wb_sel_dmem = 2'd1;
  localparam logic [1:0] c_wb_sel_pc   = 2'd2;
  localparam logic [1:0] c_wb_sel_tgt  = 2'd3;

  // One-hot instruction class; all-zero means illegal
  typedef struct packed {
    logic is_r;
    logic is_j;
    logic is_jal;
    logic is_jr;
    logic is_addi;
    logic is_sw;
    logic is_lw;
    logic is_setx;
    logic is_bex;
  } opc_class_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_opcode_decoder.sv
// ============================================================================
// Module   : opcode_decoder
// Brief    : Combinational opcode classifier: one-hot class vector + legal.
// Revision : 1.0
// ============================================================================
`default_nettype none

module opcode_decoder
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output opc_class_t          class_o,
  output logic                legal_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OPCODE_W'(c_op_r):    class_o.is_r    = 1'b1;
      OPCODE_W'(c_op_j):    class_o.is_j    = 1'b1;
      OPCODE_W'(c_op_jal):  class_o.is_jal  = 1'b1;
      OPCODE_W'(c_op_jr):   class_o.is_jr   = 1'b1;
      OPCODE_W'(c_op_addi): class_o.is_addi = 1'b1;
      OPCODE_W'(c_op_sw):   class_o.is_sw   = 1'b1;
      OPCODE_W'(c_op_lw):   class_o.is_lw   = 1'b1;
      OPCODE_W'(c_op_setx): class_o.is_setx = 1'b1;
      OPCODE_W'(c_op_bex):  class_o.is_bex  = 1'b1;
      default:              class_o         = '0;
    endcase
  end

  assign legal_o = |class_o;

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
//            handshakes, illegal/timeout traps and a retired-instruction count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                bex_cond,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                rf_we,
  output logic [1:0]          rf_dst,
  output logic [1:0]          wb_sel,
  output logic                alu_inb_imm,
  output logic                retire,
  output logic [CNT_W-1:0]    instret,
  output logic                halted,
  output logic                err_illegal,
  output logic                err_timeout
);

  localparam int              WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [OPCODE_W-1:0]   opc_q, opc_d;
  logic [CNT_W-1:0]      instret_q, instret_d;
  logic                  err_ill_q, err_ill_d;
  logic                  err_to_q, err_to_d;

  logic [OPCODE_W-1:0]   w_dec_opc;
  opc_class_t            w_cls;
  logic                  w_legal;
  logic                  w_retire;

  // The live opcode is only classified while DECODE is latching it
  assign w_dec_opc = (state_q == ST_DECODE) ? opcode : opc_q;

  opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_opcode_decoder (
    .opcode_i (w_dec_opc),
    .class_o  (w_cls),
    .legal_o  (w_legal)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    opc_d     = opc_q;
    err_ill_d = err_ill_q;
    err_to_d  = err_to_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (wait_q == c_wait_last) begin
          state_d  = ST_HALT;
          err_to_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        opc_d = opcode;
        if (w_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_HALT;
          err_ill_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (w_cls.is_r || w_cls.is_addi) begin
          state_d = ST_WB;
        end else if (w_cls.is_lw || w_cls.is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = w_cls.is_lw ? ST_WB : ST_FETCH;
        end else if (wait_q == c_wait_last) begin
          state_d  = ST_HALT;
          err_to_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    // Every fresh wait phase starts its timeout budget from zero
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
      wait_d = '0;
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = c_pc_sel_inc;
    rf_we       = 1'b0;
    rf_dst      = c_rf_dst_rd;
    wb_sel      = c_wb_sel_alu;
    alu_inb_imm = 1'b0;
    w_retire    = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_sel = c_pc_sel_inc;
        end
      end
      ST_EXEC: begin
        if (w_cls.is_addi || w_cls.is_lw || w_cls.is_sw) begin
          alu_inb_imm = 1'b1;
        end
        if (w_cls.is_j) begin
          pc_we    = 1'b1;
          pc_sel   = c_pc_sel_jump;
          w_retire = 1'b1;
        end
        if (w_cls.is_jr) begin
          pc_we    = 1'b1;
          pc_sel   = c_pc_sel_rd;
          w_retire = 1'b1;
        end
        if (w_cls.is_jal) begin
          // PC was already incremented in FETCH, so the link value is ready
          pc_we    = 1'b1;
          pc_sel   = c_pc_sel_jump;
          rf_we    = 1'b1;
          rf_dst   = c_rf_dst_r31;
          wb_sel   = c_wb_sel_pc;
          w_retire = 1'b1;
        end
        if (w_cls.is_setx) begin
          rf_we    = 1'b1;
          rf_dst   = c_rf_dst_r30;
          wb_sel   = c_wb_sel_tgt;
          w_retire = 1'b1;
        end
        if (w_cls.is_bex) begin
          pc_we    = bex_cond;
          pc_sel   = c_pc_sel_jump;
          w_retire = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = w_cls.is_sw;
        alu_inb_imm = 1'b1;
        w_retire    = dmem_ack && w_cls.is_sw;
      end
      ST_WB: begin
        rf_we       = 1'b1;
        rf_dst      = c_rf_dst_rd;
        wb_sel      = w_cls.is_lw ? c_wb_sel_dmem : c_wb_sel_alu;
        alu_inb_imm = w_cls.is_addi;
        w_retire    = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign instret_d   = instret_q + CNT_W'(w_retire);
  assign retire      = w_retire;
  assign instret     = instret_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      opc_q     <= '0;
      instret_q <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opc_q     <= opc_d;
      instret_q <= instret_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle controller for the simple processor. It replaces the single-cycle opcode decoder.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on instruction- and data-memory handshakes.
- Traps illegal opcodes and memory timeouts into a sticky HALT state.
- Keeps a retired-instruction counter. Sits between the IR/opcode field and the datapath enables.

Parameters:
OPCODE_W, 5, opcode field width
MEM_TIMEOUT, 15, max cycles to wait for any ack before timeout (≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset
opcode  in  OPCODE_W  opcode field of IR, valid from DECODE onward
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory read data valid / write done
bex_cond  in  1  1 when $rstatus != 0
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (qualified by dmem_req)
ir_we  out  1  load IR
pc_we  out  1  load PC
pc_sel  out  2  0=PC+1, 1=jump target, 2=rd register (jr), 3=reserved
rf_we  out  1  register-file write enable
rf_dst  out  2  0=rd, 1=$31 (jal), 2=$30 (setx)
wb_sel  out  2  0=ALU, 1=dmem, 2=PC (jal), 3=target immediate (setx)
alu_inb_imm  out  1  ALU operand B = sign-extended immediate
retire  out  1  one-cycle pulse on instruction completion
instret  out  CNT_W  count of retired instructions
halted  out  1  sticky HALT indicator
err_illegal  out  1  sticky: illegal opcode trapped
err_timeout  out  1  sticky: ack timeout trapped

Behaviour:
- Opcodes: R 00000, j 00001, jal 00011, jr 00100, addi 00101, sw 00111, lw 01000, setx 10101, bex 10110. Any other value is illegal.
- Reset (reset==0 at an edge): state=FETCH, wait counter=0, latched opcode=0, instret=0, all sticky flags=0. Reset overrides any in-flight wait, including MEM and HALT.
- All outputs are decoded combinationally from the state register and the latched opcode (Moore). No output depends combinationally on opcode except inside DECODE.
- FETCH: imem_req=1.
  - On imem_ack: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
- DECODE: latch opcode.
  - Legal opcode: go to EXEC.
  - Illegal opcode: go to HALT and set err_illegal.
- EXEC, by latched opcode:
  - R: go to WB.
  - addi: alu_inb_imm=1, go to WB.
  - lw/sw: alu_inb_imm=1, go to MEM.
  - j: pc_we=1, pc_sel=1, retire, go to FETCH.
  - jr: pc_we=1, pc_sel=2, retire, go to FETCH.
  - jal: pc_we=1, pc_sel=1, rf_we=1, rf_dst=1, wb_sel=2 (writes the already incremented PC), retire, go to FETCH.
  - setx: rf_we=1, rf_dst=2, wb_sel=3, retire, go to FETCH.
  - bex: pc_we=bex_cond, pc_sel=1, retire, go to FETCH.
- MEM: dmem_req=1, dmem_we=(sw), alu_inb_imm=1.
  - On dmem_ack, lw: go to WB.
  - On dmem_ack, sw: retire, go to FETCH.
- WB: rf_we=1, rf_dst=0, wb_sel=(lw ? 1 : 0), alu_inb_imm=(addi), retire, go to FETCH.
- Latency with immediate acks: R/addi/lw-less 4 cycles, lw 5, sw 4, jumps/setx/bex 3. Each wait cycle adds 1.
- Wait counter: cleared on entry to FETCH or MEM, incremented each cycle without ack.
  - If counter reaches MEM_TIMEOUT with no ack: go to HALT, set err_timeout, no enables asserted.
  - An ack in the same cycle the counter reaches MEM_TIMEOUT wins, so no timeout occurs.
- HALT: all enables and requests 0, halted=1. Remains until reset.
- instret increments by 1 on every retire. It wraps modulo 2^CNT_W with no flag.
- Exactly one retire per legal instruction. Trapped instructions never retire.

Decomposition:
- Shared package holds:
  - opcode constants;
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - pc_sel, rf_dst and wb_sel encodings.
- One natural sub-module: opcode_decoder, combinational, opcode in, one-hot is_* class vector plus legal flag out. It is instantiated on the latched opcode.

Test Plan:
- Reset mid-MEM of lw, then release → state FETCH, instret=0, imem_req=1, no dmem_req next cycle.
- addi (00101), acks immediate → rf_we high only in WB (cycle 4), alu_inb_imm=1, retire once, instret 0→1.
- lw with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, WB wb_sel=1, total latency 8 cycles.
- jal (00011) → in EXEC pc_we=1, pc_sel=1, rf_we=1, rf_dst=1, wb_sel=2. bex with bex_cond=0 → pc_we=0, retire=1.
- Opcode 11111 → HALT after DECODE, err_illegal=1, halted=1, all enables 0 for 20 further cycles, instret unchanged.
- imem_ack withheld with MEM_TIMEOUT=15 → err_timeout set after 15 wait cycles. Repeat with ack on the 15th cycle → no timeout. Run with CNT_W=4 and 17 retires → instret=1.
